// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared decode constants, FSM encoding and wait limit
// for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_JALR = 6'h09;

    localparam int WAIT_LIMIT = 15;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_JR_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational operand-usage decode and data-hazard detection
// for the instruction sitting in ID.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [5:0] id_opcode,
    input  logic [5:0] id_funct,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_wr,
    input  logic       mem_mem_read,
    input  logic [4:0] mem_wr,
    output logic       uses_rs,
    output logic       uses_rt,
    output logic       load_use,
    output logic       jr_stall1,
    output logic       jr_stall2,
    output logic       jump
);

    logic shift_imm;
    logic is_jr;
    logic ex_hits_rs;
    logic ex_hits_rt;
    logic mem_hits_rs;

    always_comb begin
        shift_imm = (id_opcode == OP_RTYPE)
                 && (id_funct == FUNCT_SLL
                  || id_funct == FUNCT_SRL
                  || id_funct == FUNCT_SRA);
        is_jr = (id_opcode == OP_RTYPE)
             && (id_funct == FUNCT_JR || id_funct == FUNCT_JALR);

        uses_rs = !(id_opcode == OP_J
                 || id_opcode == OP_JAL
                 || id_opcode == OP_LUI
                 || shift_imm);
        uses_rt = id_opcode == OP_RTYPE
               || id_opcode == OP_BEQ
               || id_opcode == OP_BNE
               || id_opcode == OP_SW;

        // $0 is hardwired, so a match on it is never a dependency
        ex_hits_rs  = (ex_wr != 5'd0) && (ex_wr == id_rs);
        ex_hits_rt  = (ex_wr != 5'd0) && (ex_wr == id_rt);
        mem_hits_rs = (mem_wr != 5'd0) && (mem_wr == id_rs);

        load_use = ex_mem_read
                && ((uses_rs && ex_hits_rs) || (uses_rt && ex_hits_rt));

        jr_stall2 = is_jr && ex_mem_read && ex_hits_rs;
        jr_stall1 = is_jr
                 && ((ex_reg_write && !ex_mem_read && ex_hits_rs)
                  || (mem_mem_read && mem_hits_rs));

        jump = id_opcode == OP_J || id_opcode == OP_JAL || is_jr;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: freeze on memory wait, branch flush,
// load-use / jr stalls, jump flush, plus stall and flush counters.
module pipeline_hazard_ctrl #(
    parameter int WAIT_LIMIT = pipeline_hazard_ctrl_pkg::WAIT_LIMIT,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_funct,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_wr,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_wr,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import pipeline_hazard_ctrl_pkg::*;

    localparam int WCW = $clog2(WAIT_LIMIT + 2);
    localparam logic [WCW-1:0] LIMIT = WCW'(WAIT_LIMIT);

    state_t         state;
    state_t         state_nx;
    state_t         ret;
    state_t         ret_nx;
    logic [WCW-1:0] wcnt;
    logic [WCW-1:0] wcnt_nx;
    logic           tmo_nx;

    logic uses_rs;
    logic uses_rt;
    logic load_use;
    logic jr_stall1;
    logic jr_stall2;
    logic jump;
    logic freeze;
    logic resume_jr;
    logic stall_req;

    hazard_detect u_hazard_detect (
        .id_opcode    (id_opcode),
        .id_funct     (id_funct),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_wr        (ex_wr),
        .mem_mem_read (mem_mem_read),
        .mem_wr       (mem_wr),
        .uses_rs      (uses_rs),
        .uses_rt      (uses_rt),
        .load_use     (load_use),
        .jr_stall1    (jr_stall1),
        .jr_stall2    (jr_stall2),
        .jump         (jump)
    );

    always_comb begin
        freeze = (mem_req && !mem_ready)
              || (state == ST_MEM_WAIT && !mem_ready);
        // on the release cycle, behave as the state we are returning to
        resume_jr = (state == ST_MEM_WAIT) ? (ret == ST_JR_WAIT)
                                           : (state == ST_JR_WAIT);
        stall_req = load_use || jr_stall1 || jr_stall2;
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        state_nx     = state;
        ret_nx       = ret;
        wcnt_nx      = wcnt;
        tmo_nx       = mem_timeout;

        if (reset) begin
            pc_write     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
            if (state != ST_MEM_WAIT) begin
                state_nx = ST_MEM_WAIT;
                ret_nx   = state;
                wcnt_nx  = WCW'(1);
            end else if (wcnt >= LIMIT) begin
                state_nx = ret;
                wcnt_nx  = '0;
                tmo_nx   = 1'b1;
            end else begin
                wcnt_nx = wcnt + WCW'(1);
            end
        end else begin
            if (state == ST_MEM_WAIT) begin
                state_nx = ret;
                wcnt_nx  = '0;
            end
            // EX holds a bubble during the jr wait, so branches are moot
            if (resume_jr) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                if (state == ST_JR_WAIT) state_nx = ST_RUN;
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (stall_req) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                if (jr_stall2 && state == ST_RUN) state_nx = ST_JR_WAIT;
            end else if (jump) begin
                if_id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            ret         <= ST_RUN;
            wcnt        <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state       <= state_nx;
            ret         <= ret_nx;
            wcnt        <= wcnt_nx;
            mem_timeout <= tmo_nx;
            if (!pc_write && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_id_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    a_lu_src: assert property (@(posedge clk) disable iff (reset)
        load_use |-> (uses_rs || uses_rt));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised and directed bench for pipeline_hazard_ctrl against
// a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int WL  = 15;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    id_opcode, id_funct;
    logic [4:0]    id_rs, id_rt, ex_wr, mem_wr;
    logic          ex_mem_read, ex_reg_write, mem_mem_read;
    logic          ex_branch_taken, mem_req, mem_ready;
    logic          pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic          if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // reference model state
    bit m_wait, m_jr, m_res_jr, m_tmo;
    int m_waited, m_stall, m_flush;
    logic [6:0] cm_e;

    pipeline_hazard_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_wr(ex_wr), .mem_mem_read(mem_mem_read), .mem_wr(mem_wr),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit hit(logic [4:0] a, logic [4:0] b);
        return a != 5'd0 && a == b;
    endfunction

    function automatic bit is_jr();
        return id_opcode == 6'h00 && (id_funct == 6'h08 || id_funct == 6'h09);
    endfunction

    function automatic bit jr2();
        return is_jr() && ex_mem_read && hit(ex_wr, id_rs);
    endfunction

    // {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, mwb_f}
    function automatic logic [6:0] exp_outs();
        bit urs, urt, lu, j1, frz, in_jr, jmp;
        urs = !(id_opcode inside {6'h02, 6'h03, 6'h0f}
             || (id_opcode == 6'h00 && id_funct inside {6'h00, 6'h02, 6'h03}));
        urt = id_opcode inside {6'h00, 6'h04, 6'h05, 6'h2b};
        lu  = ex_mem_read && ((urs && hit(ex_wr, id_rs))
                           || (urt && hit(ex_wr, id_rt)));
        j1  = is_jr() && ((ex_reg_write && !ex_mem_read && hit(ex_wr, id_rs))
                       || (mem_mem_read && hit(mem_wr, id_rs)));
        jmp = id_opcode inside {6'h02, 6'h03} || is_jr();
        frz = (mem_req && !mem_ready) || (m_wait && !mem_ready);
        in_jr = m_wait ? m_res_jr : m_jr;
        if (reset)                  return 7'b0111111;
        if (frz)                    return 7'b0000001;
        if (in_jr)                  return 7'b0011010;
        if (ex_branch_taken)        return 7'b1111110;
        if (lu || j1 || jr2())      return 7'b0011010;
        if (jmp)                    return 7'b1111100;
        return 7'b1111000;
    endfunction

    task automatic model_step(logic [6:0] e);
        bit frz;
        if (reset) begin
            m_wait = 0; m_jr = 0; m_res_jr = 0; m_tmo = 0;
            m_waited = 0; m_stall = 0; m_flush = 0;
            return;
        end
        frz = (mem_req && !mem_ready) || (m_wait && !mem_ready);
        if (frz) begin
            if (!m_wait) begin
                m_wait = 1; m_res_jr = m_jr; m_jr = 0; m_waited = 1;
            end else if (m_waited >= WL) begin
                m_wait = 0; m_waited = 0; m_tmo = 1; m_jr = m_res_jr;
            end else begin
                m_waited++;
            end
        end else if (m_wait) begin
            m_wait = 0; m_waited = 0; m_jr = m_res_jr;
        end else if (m_jr) begin
            m_jr = 0;
        end else if (!ex_branch_taken && jr2()) begin
            m_jr = 1;
        end
        if (!e[6] && m_stall < SAT) m_stall++;
        if (e[2] && m_flush < SAT) m_flush++;
    endtask

    always begin
        @(negedge clk);
        if (chk_en) begin
            cm_e = exp_outs();
            check("outs", int'({pc_write, if_id_write, id_ex_write,
                                ex_mem_write, if_id_flush, id_ex_flush,
                                mem_wb_flush}), int'(cm_e));
            check("mem_timeout", int'(mem_timeout), int'(m_tmo));
            check("stall_cnt", int'(stall_cnt), m_stall);
            check("flush_cnt", int'(flush_cnt), m_flush);
            @(posedge clk);
            model_step(cm_e);
        end
    end

    task automatic idle();
        id_opcode = 6'h00; id_funct = 6'h20; id_rs = 0; id_rt = 0;
        ex_mem_read = 0; ex_reg_write = 0; ex_wr = 0;
        mem_mem_read = 0; mem_wr = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; idle(); cyc(); reset = 0;
    endtask

    task automatic lw_in_ex(logic [4:0] r);
        ex_mem_read = 1; ex_reg_write = 1; ex_wr = r;
    endtask

    logic [5:0] ops [11] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04,
                             6'h05, 6'h0f, 6'h23, 6'h2b, 6'h08};
    logic [5:0] fns [7]  = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
                             6'h20, 6'h22};

    initial begin
        reset = 1; idle();
        cyc(); cyc();
        chk_en = 1;
        settle();
        check("rst_pc_write", int'(pc_write), 0);
        check("rst_mem_wb_flush", int'(mem_wb_flush), 1);
        check("rst_id_ex_write", int'(id_ex_write), 1);
        cyc(); reset = 0;

        // load-use on rs
        lw_in_ex(5'd8); id_rs = 8; id_rt = 9;
        settle();
        check("lu_pc_write", int'(pc_write), 0);
        check("lu_id_ex_flush", int'(id_ex_flush), 1);
        cyc(); idle();
        settle();
        check("lu_after_pc_write", int'(pc_write), 1);
        check("lu_stall_cnt", int'(stall_cnt), 1);

        // $0 and shift-immediate never stall
        cyc(); lw_in_ex(5'd0); id_rs = 0;
        settle();
        check("r0_pc_write", int'(pc_write), 1);
        cyc(); lw_in_ex(5'd8); id_funct = 6'h00; id_rs = 8; id_rt = 0;
        settle();
        check("sll_pc_write", int'(pc_write), 1);

        // jr after load: two stalls then jump flush
        cyc(); do_reset();
        lw_in_ex(5'd4); id_funct = 6'h08; id_rs = 4;
        settle();
        check("jr_s1", int'(pc_write), 0);
        cyc(); ex_mem_read = 0; ex_reg_write = 0; ex_wr = 0;
        mem_mem_read = 1; mem_wr = 4;
        settle();
        check("jr_s2", int'(pc_write), 0);
        cyc(); mem_mem_read = 0; mem_wr = 0;
        settle();
        check("jr_go_pc", int'(pc_write), 1);
        check("jr_go_flush", int'(if_id_flush), 1);
        cyc(); idle();
        settle();
        check("jr_stall_cnt", int'(stall_cnt), 2);

        // three-cycle memory wait
        cyc(); do_reset();
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("mw_frozen", int'(mem_wb_flush), 1);
            cyc();
        end
        mem_ready = 1;
        settle();
        check("mw_release", int'(pc_write), 1);
        cyc(); idle();
        settle();
        check("mw_tmo", int'(mem_timeout), 0);
        check("mw_stall_cnt", int'(stall_cnt), 3);

        // memory never ready: forced release after 16 cycles
        cyc(); do_reset();
        mem_req = 1;
        for (int i = 0; i < 16; i++) begin
            settle();
            check("to_frozen", int'(pc_write), 0);
            cyc();
        end
        mem_req = 0;
        settle();
        check("to_released", int'(mem_wb_flush), 0);
        check("to_flag", int'(mem_timeout), 1);
        check("to_stall_sat", int'(stall_cnt), SAT);
        cyc(); cyc();
        settle();
        check("to_sticky", int'(mem_timeout), 1);

        // branch beats load-use
        cyc(); do_reset();
        lw_in_ex(5'd5); id_rs = 5; ex_branch_taken = 1;
        settle();
        check("br_pc_write", int'(pc_write), 1);
        check("br_flushes", int'({if_id_flush, id_ex_flush}), 3);
        cyc(); idle();
        settle();
        check("br_flush_cnt", int'(flush_cnt), 1);
        check("br_stall_cnt", int'(stall_cnt), 0);

        // freeze during JR_WAIT resumes the jr wait
        cyc(); do_reset();
        lw_in_ex(5'd4); id_funct = 6'h09; id_rs = 4;
        cyc(); ex_mem_read = 0; ex_reg_write = 0; ex_wr = 0;
        mem_mem_read = 1; mem_wr = 4; mem_req = 1;
        settle();
        check("jw_frozen", int'(mem_wb_flush), 1);
        cyc(); cyc(); mem_ready = 1;
        settle();
        check("jw_exit_pc", int'(pc_write), 0);
        check("jw_exit_mwb", int'(mem_wb_flush), 0);
        cyc(); mem_req = 0; mem_ready = 0;
        settle();
        check("jw_again_pc", int'(pc_write), 0);
        cyc(); mem_mem_read = 0; mem_wr = 0;
        settle();
        check("jw_jump_flush", int'(if_id_flush), 1);

        // reset in the middle of a memory wait
        cyc(); idle(); mem_req = 1;
        cyc(); cyc(); reset = 1;
        settle();
        check("rw_rst_pc", int'(pc_write), 0);
        cyc(); reset = 0; mem_req = 0;
        settle();
        check("rw_run", int'(mem_wb_flush), 0);
        check("rw_cnt", int'(stall_cnt), 0);

        for (int n = 0; n < 3000; n++) begin
            cyc();
            id_opcode = ops[$urandom_range(0, 10)];
            id_funct = fns[$urandom_range(0, 6)];
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_reg_write = ex_mem_read || ($urandom_range(0, 1) == 0);
            ex_wr = 5'($urandom_range(0, 3));
            mem_mem_read = ($urandom_range(0, 2) == 0);
            mem_wr = 5'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            if (n % 500 >= 470) begin
                mem_req = 1; mem_ready = 0;
            end else begin
                mem_req = ($urandom_range(0, 3) == 0);
                mem_ready = ($urandom_range(0, 1) == 0);
            end
            reset = ($urandom_range(0, 299) == 0);
        end
        cyc(); idle(); reset = 0;
        settle();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
